// File: rtl/teacher.sv
// rtl/teacher.sv - supervised-learning teacher: feeds args to a learner, returns the signed error, counts samples

module teacher #(
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  smp_stb,
    input  logic [N:0][7:0]       smp_dat,
    output logic                  smp_rdy,
    output logic                  arg_stb,
    output logic [N-1:0][7:0]     arg_dat,
    input  logic                  arg_rdy,
    input  logic                  res_stb,
    input  logic [7:0]            res_dat,
    output logic                  res_rdy,
    output logic                  err_stb,
    output logic [15:0]           err_dat,
    input  logic                  err_rdy,
    input  logic                  fbk_stb,
    input  logic [N-1:0][15:0]    fbk_dat,
    output logic                  fbk_rdy,
    output logic [15:0]           cnt_smp,
    output logic [15:0]           cnt_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARG  = 3'd1,
        RES  = 3'd2,
        ERR  = 3'd3,
        FBK  = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  target;
    logic [8:0]  diff;
    logic [15:0] err_next;
    logic        unused_fbk;

    // Feedback contents are intentionally dropped; only the handshake matters.
    assign unused_fbk = ^fbk_dat;

    // Error is target minus result on 9 bits, then sign-extended to 16.
    assign diff     = {1'b0, target} - {1'b0, res_dat};
    assign err_next = {{7{diff[8]}}, diff};

    // Handshake FSM with registered strobes/readies; one channel open per state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            smp_rdy <= 1'b0;
            arg_stb <= 1'b0;
            res_rdy <= 1'b0;
            err_stb <= 1'b0;
            fbk_rdy <= 1'b0;
            cnt_smp <= 16'd0;
            cnt_err <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    smp_rdy <= 1'b1;
                    if (smp_stb && smp_rdy) begin
                        arg_dat <= smp_dat[N-1:0];
                        target  <= smp_dat[N];
                        smp_rdy <= 1'b0;
                        arg_stb <= 1'b1;
                        state   <= ARG;
                    end
                end
                ARG: begin
                    if (arg_rdy) begin
                        arg_stb <= 1'b0;
                        res_rdy <= 1'b1;
                        state   <= RES;
                    end
                end
                RES: begin
                    if (res_stb) begin
                        res_rdy <= 1'b0;
                        err_dat <= err_next;
                        if (err_next != 16'd0 && cnt_err != 16'hFFFF) begin
                            cnt_err <= cnt_err + 16'd1;
                        end
                        if (en) begin
                            err_stb <= 1'b1;
                            state   <= ERR;
                        end else begin
                            cnt_smp <= cnt_smp + 16'd1;
                            smp_rdy <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                ERR: begin
                    if (err_rdy) begin
                        err_stb <= 1'b0;
                        fbk_rdy <= 1'b1;
                        state   <= FBK;
                    end
                end
                FBK: begin
                    if (fbk_stb) begin
                        fbk_rdy <= 1'b0;
                        cnt_smp <= cnt_smp + 16'd1;
                        smp_rdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    smp_rdy <= 1'b0;
                    arg_stb <= 1'b0;
                    res_rdy <= 1'b0;
                    err_stb <= 1'b0;
                    fbk_rdy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_teacher.sv
// tb/tb_teacher.sv - randomized self-checking bench for teacher against a per-sample reference model

module tb_teacher;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             smp_stb = 1'b0;
    logic [2:0][7:0]  smp_dat = '0;
    logic             smp_rdy;
    logic             arg_stb;
    logic [1:0][7:0]  arg_dat;
    logic             arg_rdy = 1'b0;
    logic             res_stb = 1'b0;
    logic [7:0]       res_dat = '0;
    logic             res_rdy;
    logic             err_stb;
    logic [15:0]      err_dat;
    logic             err_rdy = 1'b0;
    logic             fbk_stb = 1'b0;
    logic [1:0][15:0] fbk_dat = '0;
    logic             fbk_rdy;
    logic [15:0]      cnt_smp;
    logic [15:0]      cnt_err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int m_smp = 0;
    int m_err = 0;
    int t0;

    teacher #(.N(2)) dut (
        .clk(clk), .rst(rst), .en(en),
        .smp_stb(smp_stb), .smp_dat(smp_dat), .smp_rdy(smp_rdy),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
        .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
        .fbk_stb(fbk_stb), .fbk_dat(fbk_dat), .fbk_rdy(fbk_rdy),
        .cnt_smp(cnt_smp), .cnt_err(cnt_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full sample; stops with ERR open when stop_in_err is set.
    task automatic do_sample(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] tgt,
                             input logic [7:0] res, input bit e, input int arg_wait,
                             input bit stop_in_err);
        logic [15:0] exp_err;
        int n;
        exp_err = 16'(int'(tgt) - int'(res));
        smp_dat = {tgt, a1, a0};
        smp_stb = 1'b1;
        n = 0;
        while (!smp_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("smp_rdy_latency", n, 0);
        @(negedge clk);
        smp_stb = 1'b0;
        smp_dat = 24'($urandom);
        for (int i = 0; i <= arg_wait; i++) begin
            chk("arg_stb", arg_stb, 1);
            chk("arg_dat", arg_dat, {a1, a0});
            chk("res_rdy_in_arg", res_rdy, 0);
            chk("smp_rdy_in_arg", smp_rdy, 0);
            if (i == arg_wait) begin
                arg_rdy = 1'b1;
                res_stb = 1'b0;
            end else begin
                res_stb = 1'($urandom_range(0, 1));
                res_dat = 8'($urandom);
                en = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        arg_rdy = 1'b0;
        chk("arg_stb_after", arg_stb, 0);
        chk("res_rdy", res_rdy, 1);
        res_stb = 1'b1;
        res_dat = res;
        en = e;
        @(negedge clk);
        res_stb = 1'b0;
        en = 1'($urandom_range(0, 1));
        if (exp_err != 16'd0 && m_err < 65535) m_err++;
        chk("res_rdy_after", res_rdy, 0);
        if (!e) begin
            m_smp = (m_smp + 1) % 65536;
            chk("smp_rdy_inf", smp_rdy, 1);
            chk("err_stb_inf", err_stb, 0);
            chk("fbk_rdy_inf", fbk_rdy, 0);
            chk("cnt_smp", cnt_smp, m_smp);
            chk("cnt_err", cnt_err, m_err);
            return;
        end
        chk("err_stb", err_stb, 1);
        chk("err_dat", err_dat, exp_err);
        chk("cnt_err_res", cnt_err, m_err);
        chk("fbk_rdy_in_err", fbk_rdy, 0);
        if (stop_in_err) return;
        err_rdy = 1'b1;
        @(negedge clk);
        err_rdy = 1'b0;
        chk("err_stb_after", err_stb, 0);
        chk("fbk_rdy", fbk_rdy, 1);
        fbk_stb = 1'b1;
        fbk_dat = 32'($urandom);
        @(negedge clk);
        fbk_stb = 1'b0;
        m_smp = (m_smp + 1) % 65536;
        chk("fbk_rdy_after", fbk_rdy, 0);
        chk("smp_rdy_train", smp_rdy, 1);
        chk("cnt_smp", cnt_smp, m_smp);
        chk("cnt_err", cnt_err, m_err);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_smp_rdy", smp_rdy, 0);
        chk("rst_arg_stb", arg_stb, 0);
        chk("rst_res_rdy", res_rdy, 0);
        chk("rst_err_stb", err_stb, 0);
        chk("rst_fbk_rdy", fbk_rdy, 0);
        chk("rst_cnt_smp", cnt_smp, 0);
        chk("rst_cnt_err", cnt_err, 0);
        m_smp = 0;
        m_err = 0;
        rst = 1'b1;
        @(negedge clk);
        chk("release_smp_rdy", smp_rdy, 1);
    endtask

    initial begin
        @(negedge clk);
        apply_reset();

        do_sample(8'd3, 8'd5, 8'hFF, 8'h00, 1'b1, 0, 1'b0);
        chk("ex1_cnt_smp", cnt_smp, 1);
        chk("ex1_cnt_err", cnt_err, 1);
        do_sample(8'h11, 8'h22, 8'h00, 8'hFF, 1'b1, 1, 1'b0);
        do_sample(8'h44, 8'h55, 8'h80, 8'h80, 1'b1, 2, 1'b0);
        chk("zero_err_cnt_err", cnt_err, 2);

        t0 = cyc;
        for (int k = 0; k < 3; k++)
            do_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 0, 1'b0);
        chk("inf_throughput", cyc - t0, 9);
        t0 = cyc;
        do_sample(8'h01, 8'h02, 8'h10, 8'h20, 1'b1, 0, 1'b0);
        chk("train_throughput", cyc - t0, 5);

        do_sample(8'hA5, 8'h5A, 8'h7F, 8'h01, 1'b1, 10, 1'b0);

        for (int k = 0; k < 40; k++)
            do_sample(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);

        do_sample(8'h09, 8'h08, 8'h40, 8'h20, 1'b1, 0, 1'b1);
        apply_reset();
        do_sample(8'h01, 8'h01, 8'h33, 8'h33, 1'b1, 0, 1'b0);
        chk("post_rst_cnt_smp", cnt_smp, 1);

        force dut.cnt_smp = 16'hFFFE;
        force dut.cnt_err = 16'hFFFE;
        #1;
        release dut.cnt_smp;
        release dut.cnt_err;
        m_smp = 65534;
        m_err = 65534;
        do_sample(8'h00, 8'h00, 8'h05, 8'h01, 1'b1, 0, 1'b0);
        chk("sat_cnt_err_ffff", cnt_err, 16'hFFFF);
        do_sample(8'h00, 8'h00, 8'h01, 8'h05, 1'b0, 0, 1'b0);
        chk("sat_cnt_err_hold", cnt_err, 16'hFFFF);
        chk("wrap_cnt_smp", cnt_smp, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/teacher.md
TEACHER -- requirements
Module: teacher

Interface
REQ-001 The block SHALL have parameter N, default 2, giving the number of 8-bit arguments per sample.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the reset: synchronous, active-low.
REQ-004 The block SHALL have port en, input, 1 bit: training enable, 1 = train, 0 = inference only.
REQ-005 The block SHALL have ports smp_stb (input, 1), smp_dat (input, [N][8] args + [8] target, target in the top byte) and smp_rdy (output, 1): the labelled sample stream.
REQ-006 The block SHALL have ports arg_stb (output, 1), arg_dat (output, [N-1:0][7:0]) and arg_rdy (input, 1): arguments to the learner.
REQ-007 The block SHALL have ports res_stb (input, 1), res_dat (input, 8) and res_rdy (output, 1): the learner result.
REQ-008 The block SHALL have ports err_stb (output, 1), err_dat (output, 16) and err_rdy (input, 1): error to the learner.
REQ-009 The block SHALL have ports fbk_stb (input, 1), fbk_dat (input, [N-1:0][15:0]) and fbk_rdy (output, 1): learner feedback, consumed and discarded.
REQ-010 The block SHALL have ports cnt_smp (output, 16), the samples completed, and cnt_err (output, 16), the samples with nonzero error.

Function
REQ-011 On every channel, a transfer SHALL occur on a cycle with stb=1 and rdy=1; a driven stb SHALL stay high with stable dat until it transfers.
REQ-012 The FSM SHALL have the states IDLE, ARG, RES, ERR and FBK; exactly one handshake is open per state.
REQ-013 In IDLE, smp_rdy=1 and all other rdy/stb outputs are 0; on a smp transfer the block SHALL latch the args and the target and go to ARG.
REQ-014 In ARG, arg_stb=1 and arg_dat=latched args, first asserted the cycle after the smp transfer; on arg_rdy the block SHALL go to RES.
REQ-015 In RES, res_rdy=1; on res_stb the block SHALL latch res_dat and compute err = sign-extend-16(zero-ext-9(target) - zero-ext-9(res)).
REQ-016 After the RES transfer, with en=1 the block SHALL go to ERR; with en=0 it SHALL return to IDLE, skipping ERR and FBK.
REQ-017 en SHALL be sampled only on the RES transfer cycle; changes to en in other states have no effect on the sample in flight.
REQ-018 In ERR, err_stb=1 and err_dat=the computed err, including when err=0; on err_rdy the block SHALL go to FBK.
REQ-019 In FBK, fbk_rdy=1; on fbk_stb the block SHALL discard fbk_dat and return to IDLE.
REQ-020 cnt_smp SHALL increment on the transfer that completes a sample (the FBK transfer, or the RES transfer when en=0); it wraps 0xFFFF->0.
REQ-021 cnt_err SHALL increment on the RES transfer when the computed err != 0 (in both training and inference), and saturate at 0xFFFF.
REQ-022 Inputs arriving outside their state (e.g. res_stb in ARG, fbk_stb in ERR) SHALL be ignored, with their rdy held low.
REQ-023 Throughput SHALL be at most one sample per 5 cycles when en=1 and per 3 cycles when en=0, with zero-wait partners.

Reset
REQ-024 While rst=0 at a clock edge, the block SHALL enter IDLE and set smp_rdy=0, arg_stb=0, res_rdy=0, err_stb=0, fbk_rdy=0, cnt_smp=0 and cnt_err=0.
REQ-025 In the first cycle after rst is released, smp_rdy SHALL become 1.
REQ-026 Reset asserted in any state SHALL abort the in-flight sample without counting it; no stb stays high after the reset edge.
REQ-027 Data registers need not be reset; every data output is qualified by its stb.

Verification
REQ-028 N=2, en=1, sample args {3,5}, target 0xFF, learner returns res 0x00 -> arg_dat={3,5}, err_dat=0x00FF; after the fbk transfer cnt_smp=1, cnt_err=1.
REQ-029 Target 0x00, res 0xFF, en=1 -> err_dat=0xFF01 (-255); target 0x80, res 0x80 -> err_stb still asserted with err_dat=0x0000, and cnt_err unchanged.
REQ-030 en=0, three samples with zero-wait partners -> err_stb and fbk_rdy never 1, cnt_smp=3, and smp_rdy asserted every 3rd cycle.
REQ-031 arg_rdy held low 10 cycles -> arg_stb and arg_dat stable for all 10 cycles; res_stb pulsed during ARG -> ignored, and res_rdy stays 0.
REQ-032 rst=0 asserted while in ERR -> next cycle err_stb=0 and counters=0; after release, the next sample completes normally with cnt_smp=1.
REQ-033 Preload via 65535 nonzero-error samples (or force) -> cnt_err stays at 0xFFFF on the next error while cnt_smp wraps to 0 on sample 65536.
